// File: rtl/instr_encoder_loader.sv
// Sequential instruction encoder and program loader.
//
// Accepts symbolic instruction descriptors over a valid/ready handshake,
// packs each into a 32-bit instruction word and writes it to instruction
// memory at consecutive word addresses starting at BASE_ADR.
//
// Optional feature macro: ENC_FP_EN
//   defined   : kind 4 encodes floating-point words
//   undefined : kind 4 is illegal and no FP encoding logic is built
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no session open; waits for start
// ACCEPT | in_ready high; waits for a descriptor handshake
// WRITE  | latched word driven on the memory port for one cycle
// DONE   | one-cycle done pulse, then back to IDLE
//
// MAX_WORDS must not exceed 511 so the index fits the 9-bit words port.

module instr_encoder_loader #(
   parameter int          MAX_WORDS = 256,
   parameter logic [31:0] BASE_ADR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_last,
   input  logic [2:0]  kind,
   input  logic [3:0]  cond,
   input  logic [3:0]  op,
   input  logic        s_bit,
   input  logic        i_bit,
   input  logic        u_bit,
   input  logic [3:0]  rn,
   input  logic [3:0]  rd,
   input  logic [3:0]  rs,
   input  logic [3:0]  rm,
   input  logic [23:0] imm,
   output logic        MemWE,
   output logic [31:0] MemAdr,
   output logic [31:0] MemWD,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [8:0]  words
);

   localparam logic [8:0] MAX_W = 9'(MAX_WORDS);

   localparam logic [2:0] KIND_DP  = 3'd0;
   localparam logic [2:0] KIND_MEM = 3'd1;
   localparam logic [2:0] KIND_BR  = 3'd2;
   localparam logic [2:0] KIND_MUL = 3'd3;
   localparam logic [2:0] KIND_FP  = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_WRITE  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [8:0]  idx;
   logic        last_q;
   logic [31:0] enc_word;
   logic        enc_legal;
   logic [11:0] dp_op2;
   logic [11:0] mem_off;
   logic        hs;
   logic        cap_full;

   assign hs       = (state == S_ACCEPT) && in_valid;
   assign cap_full = (idx + 9'd1) >= MAX_W;
   assign words    = idx;

   // operand fields shared by the DP and MEM formats
   always_comb begin
      dp_op2  = i_bit ? {rs, imm[7:0]} : {8'b0, rm};
      mem_off = i_bit ? imm[11:0]      : {8'b0, rm};
   end

   // pack the presented descriptor and flag kinds/subops with no encoding
   always_comb begin
      enc_word  = 32'h0;
      enc_legal = 1'b0;
      case (kind)
         KIND_DP: begin
            enc_legal = 1'b1;
            enc_word  = {cond, 2'b00, i_bit, op, s_bit, rn, rd, dp_op2};
         end
         KIND_MEM: begin
            enc_legal = 1'b1;
            enc_word  = {cond, 2'b01, ~i_bit, 1'b1, u_bit, 1'b0, 1'b0,
                         s_bit, rn, rd, mem_off};
         end
         KIND_BR: begin
            enc_legal = 1'b1;
            enc_word  = {cond, 3'b101, s_bit, imm};
         end
         KIND_MUL: begin
            // only MUL, UMULL and SMULL subops have a defined encoding
            enc_legal = (op == 4'b0000) || (op == 4'b0100) || (op == 4'b0110);
            enc_word  = {cond, 3'b000, op, s_bit, rn, rd, rs, 4'b1001, rm};
         end
         KIND_FP: begin
`ifdef ENC_FP_EN
            enc_legal = 1'b1;
            enc_word  = {cond, 2'b11, 1'b0, op, s_bit, rn, rd, 8'h00, rm};
`else
            enc_legal = 1'b0;
            enc_word  = 32'h0;
`endif
         end
         default: begin
            enc_legal = 1'b0;
            enc_word  = 32'h0;
         end
      endcase
   end

   // session sequencing: next state and state-decoded outputs
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      MemWE    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_ACCEPT;
         end
         S_ACCEPT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               if (enc_legal)    state_nx = S_WRITE;
               else if (in_last) state_nx = S_DONE;
            end
         end
         S_WRITE: begin
            MemWE = 1'b1;
            busy  = 1'b1;
            if (last_q || cap_full) state_nx = S_DONE;
            else                    state_nx = S_ACCEPT;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // state register, word/address latch, index and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         idx    <= 9'd0;
         last_q <= 1'b0;
         err    <= 1'b0;
         MemWD  <= 32'h0;
         MemAdr <= 32'h0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && start) begin
            idx <= 9'd0;
            err <= 1'b0;
         end
         if (hs) begin
            last_q <= in_last;
            if (enc_legal) begin
               MemWD  <= enc_word;
               MemAdr <= BASE_ADR + {21'b0, idx, 2'b00};
            end else begin
               err <= 1'b1;
            end
         end
         if (state == S_WRITE) idx <= idx + 9'd1;
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader.
// Directed cases pin known encodings; random sessions run against a
// transaction-level model (expected-write queue, index, sticky error).

module tb_instr_encoder_loader;

   localparam int          MAXW  = 4;
   localparam logic [31:0] BASE  = 32'hFFFF_FFF8;
   localparam bit          FP_EN = 1'b0;

   logic        clk = 1'b0;
   logic        reset, start, in_valid, in_last;
   logic [2:0]  kind;
   logic [3:0]  cond, op, rn, rd, rs, rm;
   logic        s_bit, i_bit, u_bit;
   logic [23:0] imm;
   logic        in_ready, MemWE, busy, done, err;
   logic [31:0] MemAdr, MemWD;
   logic [8:0]  words;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   int          m_index = 0;
   bit          m_err = 1'b0;
   bit          m_open = 1'b0;

   instr_encoder_loader #(.MAX_WORDS(MAXW), .BASE_ADR(BASE)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .in_last(in_last), .kind(kind), .cond(cond),
      .op(op), .s_bit(s_bit), .i_bit(i_bit), .u_bit(u_bit), .rn(rn),
      .rd(rd), .rs(rs), .rm(rm), .imm(imm), .MemWE(MemWE),
      .MemAdr(MemAdr), .MemWD(MemWD), .busy(busy), .done(done),
      .err(err), .words(words)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // instruction word built field by field with shifts and adds
   function automatic logic [32:0] model_enc(
      input logic [2:0] k, input logic [3:0] c, input logic [3:0] o,
      input logic s, input logic i, input logic u,
      input logic [3:0] n, input logic [3:0] d, input logic [3:0] r_s,
      input logic [3:0] m, input logic [23:0] im);
      logic [31:0] w;
      logic        ok;
      w  = 32'(c) << 28;
      ok = 1'b1;
      case (k)
         3'd0: w = w + (32'(i) << 25) + (32'(o) << 21) + (32'(s) << 20)
                     + (32'(n) << 16) + (32'(d) << 12)
                     + (i ? ((32'(r_s) << 8) + 32'(im[7:0])) : 32'(m));
         3'd1: w = w + (32'd1 << 26) + (32'(!i) << 25) + (32'd1 << 24)
                     + (32'(u) << 23) + (32'(s) << 20) + (32'(n) << 16)
                     + (32'(d) << 12) + (i ? 32'(im[11:0]) : 32'(m));
         3'd2: w = w + (32'd5 << 25) + (32'(s) << 24) + 32'(im);
         3'd3: begin
            ok = (o == 4'd0) || (o == 4'd4) || (o == 4'd6);
            w  = w + (32'(o) << 21) + (32'(s) << 20) + (32'(n) << 16)
                   + (32'(d) << 12) + (32'(r_s) << 8) + (32'd9 << 4) + 32'(m);
         end
         3'd4: begin
            ok = FP_EN;
            w  = w + (32'd3 << 26) + (32'(o) << 21) + (32'(s) << 20)
                   + (32'(n) << 16) + (32'(d) << 12) + 32'(m);
         end
         default: ok = 1'b0;
      endcase
      return {ok, w};
   endfunction

   // every memory write must match the oldest expected write
   always @(negedge clk) begin : cmp
      logic [63:0] x;
      if (MemWE) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write adr=%h wd=%h required=no write", MemAdr, MemWD);
         end else begin
            x = exp_q.pop_front();
            chk("write_adr", MemAdr, x[63:32]);
            chk("write_wd", MemWD, x[31:0]);
         end
      end
      if (done) chk("busy_low_with_done", {31'b0, busy}, 32'd0);
   end

   task automatic set_desc(input logic [2:0] k, input logic [3:0] c, input logic [3:0] o,
                           input logic s, input logic i, input logic u,
                           input logic [3:0] n, input logic [3:0] d,
                           input logic [3:0] r_s, input logic [3:0] m,
                           input logic [23:0] im);
      kind = k; cond = c; op = o; s_bit = s; i_bit = i; u_bit = u;
      rn = n; rd = d; rs = r_s; rm = m; imm = im;
   endtask

   task automatic rand_desc();
      int r;
      logic [3:0] mops[3];
      mops[0] = 4'd0; mops[1] = 4'd4; mops[2] = 4'd6;
      r = $urandom_range(0, 9);
      kind  = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r == 4) ? 3'd2 :
              (r < 7) ? 3'd3 : (r == 7) ? 3'd4 : 3'($urandom_range(5, 7));
      cond  = 4'($urandom);
      op    = 4'($urandom);
      if (kind == 3'd3 && $urandom_range(0, 3) != 0) op = mops[$urandom_range(0, 2)];
      s_bit = 1'($urandom); i_bit = 1'($urandom); u_bit = 1'($urandom);
      rn = 4'($urandom); rd = 4'($urandom); rs = 4'($urandom); rm = 4'($urandom);
      imm = 24'($urandom);
   endtask

   task automatic do_start(input bit with_valid);
      start = 1'b1;
      if (with_valid) begin
         set_desc(3'd0, 4'hE, 4'h4, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 4'd0, 24'd5);
         in_valid = 1'b1;
         in_last  = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      m_open = 1'b1; m_index = 0; m_err = 1'b0;
      chk("start_ready", {31'b0, in_ready}, 32'd1);
      chk("start_busy", {31'b0, busy}, 32'd1);
      chk("start_words_clr", 32'(words), 32'd0);
      chk("start_err_clr", {31'b0, err}, 32'd0);
   endtask

   // offer the current descriptor; all tasks begin and end just after a negedge
   task automatic offer(input bit lst, input bit rst_w, input bit lit,
                        input logic [31:0] lit_wd, input logic [31:0] lit_adr);
      logic [32:0] e;
      bit          legal, ending;
      int          t;
      in_last  = lst;
      in_valid = 1'b1;
      e     = model_enc(kind, cond, op, s_bit, i_bit, u_bit, rn, rd, rs, rm, imm);
      legal = e[32];
      if (!m_open) begin
         repeat (3) begin
            chk("no_accept_when_closed", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
         end
         in_valid = 1'b0; in_last = 1'b0;
         return;
      end
      t = 0;
      while (!in_ready && t < 4) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk("ready_timeout", {31'b0, in_ready}, 32'd1);
         in_valid = 1'b0; in_last = 1'b0; m_open = 1'b0;
         return;
      end
      if (legal) begin
         exp_q.push_back({BASE + 32'(m_index) * 32'd4, e[31:0]});
         m_index++;
      end else begin
         m_err = 1'b1;
      end
      ending = lst || (legal && m_index == MAXW);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      chk("ready_after_hs", {31'b0, in_ready}, {31'b0, (!legal && !ending)});
      if (legal) begin
         chk("we_after_hs", {31'b0, MemWE}, 32'd1);
         if (lit) begin
            chk("lit_wd", MemWD, lit_wd);
            chk("lit_adr", MemAdr, lit_adr);
         end
         if (rst_w) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("rst_we", {31'b0, MemWE}, 32'd0);
            chk("rst_adr", MemAdr, 32'd0);
            chk("rst_wd", MemWD, 32'd0);
            chk("rst_words", 32'(words), 32'd0);
            chk("rst_flags", {27'b0, in_ready, busy, done, err, MemWE}, 32'd0);
            exp_q.delete();
            m_open = 1'b0; m_index = 0; m_err = 1'b0;
            return;
         end
      end else begin
         chk("err_set", {31'b0, err}, 32'd1);
      end
      if (ending) begin
         if (legal) @(negedge clk);
         chk("done_pulse", {31'b0, done}, 32'd1);
         chk("busy_in_done", {31'b0, busy}, 32'd0);
         @(negedge clk);
         chk("done_one_cycle", {31'b0, done}, 32'd0);
         chk("words_end", 32'(words), 32'(m_index));
         chk("err_end", {31'b0, err}, {31'b0, m_err});
         chk("queue_drained", 32'(exp_q.size()), 32'd0);
         m_open = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      set_desc(3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_we", {31'b0, MemWE}, 32'd0);
      chk("reset_adr", MemAdr, 32'd0);
      chk("reset_wd", MemWD, 32'd0);
      chk("reset_words", 32'(words), 32'd0);
      chk("reset_flags", {27'b0, in_ready, busy, done, err, MemWE}, 32'd0);

      // session A: start with in_valid, known encodings, illegal kinds, address wrap
      do_start(1'b1);
      set_desc(3'd0, 4'hE, 4'h4, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 4'd0, 24'd5);
      offer(1'b0, 1'b0, 1'b1, 32'hE2821005, BASE);
      set_desc(3'd1, 4'hE, 4'h0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd3, 4'd0, 4'd0, 24'd8);
      offer(1'b0, 1'b0, 1'b1, 32'hE5843008, 32'hFFFF_FFFC);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      chk("start_busy_ignored_words", 32'(words), 32'd2);
      chk("start_busy_ignored_ready", {31'b0, in_ready}, 32'd1);
      set_desc(3'd3, 4'hE, 4'h2, 1'b1, 1'b0, 1'b0, 4'd5, 4'd4, 4'd3, 4'd2, 24'd0);
      offer(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_desc(3'd6, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 24'd0);
      offer(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_desc(3'd4, 4'hE, 4'h3, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd0, 4'd1, 24'd0);
      offer(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("illegal_no_advance", 32'(words), 32'd2);
      set_desc(3'd0, 4'hE, 4'h4, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 4'd0, 24'd5);
      offer(1'b0, 1'b0, 1'b1, 32'hE2821005, 32'h0000_0000);
      set_desc(3'd3, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0, 4'd5, 4'd4, 4'd3, 4'd2, 24'd0);
      offer(1'b1, 1'b0, 1'b1, 32'hE0954392, 32'h0000_0004);

      // session B: single branch word
      do_start(1'b0);
      set_desc(3'd2, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE);
      offer(1'b1, 1'b0, 1'b1, 32'hEAFFFFFE, BASE);
      chk("br_words", 32'(words), 32'd1);

      // session C: capacity limit with six offers and no in_last
      do_start(1'b0);
      for (int k = 0; k < 6; k++) begin
         set_desc(3'd0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                  4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 24'($urandom));
         offer(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      chk("cap_words", 32'(words), 32'd4);

      // session D: reset during the WRITE cycle
      do_start(1'b0);
      set_desc(3'd1, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 4'd7, 4'd6, 4'd0, 4'd9, 24'd0);
      offer(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);

      // session E: illegal descriptor carrying in_last ends the session directly
      do_start(1'b0);
      set_desc(3'd5, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'd0);
      offer(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("illegal_last_words", 32'(words), 32'd0);

      // randomized sessions
      for (int sidx = 0; sidx < 40; sidx++) begin
         int  n;
         bit  use_last;
         do_start(1'($urandom));
         n        = $urandom_range(1, 6);
         use_last = ($urandom_range(0, 2) != 0);
         for (int k = 0; k < n; k++) begin
            rand_desc();
            if (m_open) repeat ($urandom_range(0, 1)) @(negedge clk);
            offer(use_last && (k == n - 1), 1'b0, 1'b0, 32'd0, 32'd0);
         end
         if (m_open) begin
            set_desc(3'd0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                     4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 24'($urandom));
            offer(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
         end
      end

      repeat (2) @(negedge clk);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
